// File: rtl/msgpu_pkg.sv
// Shared MSGPU constants: command address map and pixel sizing helper.
// Imported by the pixel stream assembler and its FIFO.
package msgpu_pkg;

  localparam int PIXEL_ADDRESS_DEF = 10;
  localparam int CLEAR_ADDRESS_DEF = 11;

  // Controller states; ARMED is qualified by the byte index register.
  localparam logic ST_DISARMED = 1'b0;
  localparam logic ST_ARMED    = 1'b1;

  function automatic int bytes_per_pixel(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and level.
// Ports: clk, rst_n, push/push_data, pop, flush, head/level/full/empty.
module pixel_fifo
  import msgpu_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // A push on a full FIFO still lands if a pop frees a slot this edge.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Head is forced to zero when empty so no stale entry is visible.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_assembler.sv
// Packs big-endian MCU bytes into pixels and queues them in a FIFO.
// Ports: byte/command strobes in; valid/ready pixel stream, level, overflow out.
module pixel_stream_assembler
  import msgpu_pkg::*;
#(
  parameter int PIXEL_WIDTH   = 12,
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int PIXEL_ADDRESS = PIXEL_ADDRESS_DEF,
  parameter int CLEAR_ADDRESS = CLEAR_ADDRESS_DEF
) (
  input  logic                        system_clock,
  input  logic                        reset_n,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  input  logic                        command_valid,
  input  logic [ADDR_WIDTH-1:0]       command_address,
  output logic                        pixel_valid,
  input  logic                        pixel_ready,
  output logic [PIXEL_WIDTH-1:0]      pixel_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int BPP   = bytes_per_pixel(PIXEL_WIDTH);
  localparam int IDX_W = (BPP > 1) ? $clog2(BPP) : 1;
  // Low bits carried by the final byte of each pixel.
  localparam int REM   = PIXEL_WIDTH - 8 * (BPP - 1);

  logic                   state;
  logic [IDX_W-1:0]       idx;
  logic [PIXEL_WIDTH-1:0] partial;
  logic [PIXEL_WIDTH-1:0] partial_nxt;
  logic [PIXEL_WIDTH-1:0] push_data;
  logic                   cmd_pixel;
  logic                   cmd_clear;
  logic                   byte_take;
  logic                   last_byte;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   unused_bits;

  assign unused_bits = ^byte_data;

  assign cmd_pixel = command_valid &&
    (command_address == ADDR_WIDTH'(PIXEL_ADDRESS));
  assign cmd_clear = command_valid &&
    (command_address == ADDR_WIDTH'(CLEAR_ADDRESS));

  // A concurrent command always takes priority over the byte.
  assign byte_take = byte_valid && !command_valid &&
    (state == ST_ARMED);
  assign last_byte = (idx == IDX_W'(BPP - 1));
  assign push      = byte_take && last_byte;
  assign pop       = pixel_valid && pixel_ready;

  // Non-final bytes never touch the low REM bits, so OR is exact.
  assign push_data = partial |
    PIXEL_WIDTH'(byte_data[REM-1:0]);

  always_comb begin
    partial_nxt = partial;
    for (int k = 0; k < BPP - 1; k++) begin
      if (idx == IDX_W'(k)) begin
        partial_nxt[PIXEL_WIDTH-1-8*k -: 8] = byte_data;
      end
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_DISARMED;
      idx     <= '0;
      partial <= '0;
    end else if (command_valid) begin
      if (cmd_pixel) begin
        state   <= ST_ARMED;
        idx     <= '0;
        partial <= '0;
      end else if (!cmd_clear) begin
        state   <= ST_DISARMED;
        idx     <= '0;
        partial <= '0;
      end
    end else if (byte_take) begin
      if (last_byte) begin
        idx     <= '0;
        partial <= '0;
      end else begin
        idx     <= idx + 1'b1;
        partial <= partial_nxt;
      end
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (cmd_clear) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  pixel_fifo #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (system_clock),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (cmd_clear),
    .head      (pixel_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pixel_valid = !fifo_empty;

endmodule

// File: tb/tb_pixel_stream_assembler.sv
// Directed bench for pixel_stream_assembler (12-bit and 24-bit builds).
// Drives on the falling edge and samples there too.
module tb_pixel_stream_assembler;

  logic        clk;
  logic        rst_n;

  logic        bv, cv, pr, pv, ovf;
  logic [7:0]  bd;
  logic [31:0] ca;
  logic [11:0] pd;
  logic [4:0]  lvl;

  logic        bv_w, cv_w, pr_w, pv_w, ovf_w;
  logic [7:0]  bd_w;
  logic [31:0] ca_w;
  logic [23:0] pd_w;
  logic [4:0]  lvl_w;

  int n_chk;
  int n_fail;
  logic [11:0] exp_q[$];

  pixel_stream_assembler #(
    .PIXEL_WIDTH (12)
  ) dut (
    .system_clock    (clk),
    .reset_n         (rst_n),
    .byte_valid      (bv),
    .byte_data       (bd),
    .command_valid   (cv),
    .command_address (ca),
    .pixel_valid     (pv),
    .pixel_ready     (pr),
    .pixel_data      (pd),
    .fifo_level      (lvl),
    .overflow        (ovf)
  );

  pixel_stream_assembler #(
    .PIXEL_WIDTH (24)
  ) dut_w (
    .system_clock    (clk),
    .reset_n         (rst_n),
    .byte_valid      (bv_w),
    .byte_data       (bd_w),
    .command_valid   (cv_w),
    .command_address (ca_w),
    .pixel_valid     (pv_w),
    .pixel_ready     (pr_w),
    .pixel_data      (pd_w),
    .fifo_level      (lvl_w),
    .overflow        (ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input bit w, input logic [7:0] b);
    if (w) begin bv_w = 1'b1; bd_w = b; end
    else   begin bv   = 1'b1; bd   = b; end
    @(negedge clk);
    bv   = 1'b0;
    bv_w = 1'b0;
  endtask

  task automatic send_cmd(input bit w, input logic [31:0] a);
    if (w) begin cv_w = 1'b1; ca_w = a; end
    else   begin cv   = 1'b1; ca   = a; end
    @(negedge clk);
    cv   = 1'b0;
    cv_w = 1'b0;
  endtask

  task automatic pop_one(input bit w);
    if (w) pr_w = 1'b1;
    else   pr   = 1'b1;
    @(negedge clk);
    pr   = 1'b0;
    pr_w = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] e;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bv = 0; bd = 0; cv = 0; ca = 0; pr = 0;
    bv_w = 0; bd_w = 0; cv_w = 0; ca_w = 0; pr_w = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(pv), 32'd0);
    check("rst_data", 32'(pd), 32'd0);
    check("rst_level", 32'(lvl), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic packing
    send_cmd(0, 32'd10);
    send_byte(0, 8'hAB);
    check("t1_early", 32'(pv), 32'd0);
    send_byte(0, 8'hCD);
    check("t1_valid", 32'(pv), 32'd1);
    check("t1_data", 32'(pd), 32'hABD);
    check("t1_level", 32'(lvl), 32'd1);
    pop_one(0);
    check("t1_popped", 32'(lvl), 32'd0);

    // Disarmed bytes are dropped
    do_reset();
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    check("t2_valid", 32'(pv), 32'd0);
    check("t2_level", 32'(lvl), 32'd0);

    // Resync discards partial pixel
    send_cmd(0, 32'd10);
    send_byte(0, 8'hAB);
    send_cmd(0, 32'd10);
    send_byte(0, 8'h11);
    send_byte(0, 8'h2F);
    check("t3_level", 32'(lvl), 32'd1);
    check("t3_data", 32'(pd), 32'h11F);
    pop_one(0);
    check("t3_empty", 32'(pv), 32'd0);

    // Overflow with 17 pushes
    for (int i = 0; i < 17; i++) begin
      b0 = 8'h10 + 8'(i);
      b1 = 8'(i);
      exp_q.push_back({b0, b1[3:0]});
      send_byte(0, b0);
      send_byte(0, b1);
    end
    check("t4_level", 32'(lvl), 32'd16);
    check("t4_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      check($sformatf("t4_drain%0d", i), 32'(pd), 32'(e));
      pop_one(0);
    end
    exp_q.delete();
    check("t4_drained", 32'(lvl), 32'd0);
    check("t4_ovf_sticky", 32'(ovf), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_byte(0, 8'h77);
      send_byte(0, 8'h01);
    end
    check("t4_refill", 32'(lvl), 32'd3);
    send_cmd(0, 32'd11);
    check("t4_clr_level", 32'(lvl), 32'd0);
    check("t4_clr_ovf", 32'(ovf), 32'd0);
    check("t4_clr_valid", 32'(pv), 32'd0);

    // Push and pop together on a full FIFO
    for (int i = 0; i < 16; i++) begin
      b0 = 8'h40 + 8'(i);
      b1 = 8'(i);
      exp_q.push_back({b0, b1[3:0]});
      send_byte(0, b0);
      send_byte(0, b1);
    end
    check("t5_full", 32'(lvl), 32'd16);
    send_byte(0, 8'hEE);
    pr = 1'b1;
    send_byte(0, 8'h05);
    pr = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(12'hEE5);
    check("t5_level", 32'(lvl), 32'd16);
    check("t5_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      check($sformatf("t5_drain%0d", i), 32'(pd), 32'(e));
      pop_one(0);
    end
    check("t5_empty", 32'(lvl), 32'd0);

    // Command beats a same-cycle byte
    send_byte(0, 8'hAB);
    bv = 1'b1; bd = 8'h55;
    cv = 1'b1; ca = 32'd10;
    @(negedge clk);
    bv = 1'b0; cv = 1'b0;
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    check("t5b_level", 32'(lvl), 32'd1);
    check("t5b_data", 32'(pd), 32'h124);

    // Other address disarms
    send_cmd(0, 32'd5);
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    check("t5c_level", 32'(lvl), 32'd1);
    pop_one(0);

    // 24-bit build
    send_cmd(1, 32'd10);
    send_byte(1, 8'h01);
    send_byte(1, 8'h02);
    send_byte(1, 8'h03);
    check("t6_valid", 32'(pv_w), 32'd1);
    check("t6_data", 32'(pd_w), 32'h010203);
    pop_one(1);
    send_byte(1, 8'h0A);
    send_byte(1, 8'h0B);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(pv_w), 32'd0);
    check("t6_rst_level", 32'(lvl_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(1, 8'h0C);
    check("t6_disarmed", 32'(pv_w), 32'd0);
    send_cmd(1, 32'd10);
    send_byte(1, 8'h0A);
    send_byte(1, 8'h0B);
    check("t6_partial", 32'(pv_w), 32'd0);
    send_byte(1, 8'h0C);
    check("t6_fresh_valid", 32'(pv_w), 32'd1);
    check("t6_fresh_data", 32'(pd_w), 32'h0A0B0C);
    check("t6_fresh_level", 32'(lvl_w), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
